// File: rtl/pp_job_pkg.sv
// Shared types for the packet-parser job sequencer: FSM states, job/result
// records and the bit layout of the result status nibble.
package pp_job_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_IRQ,
    CAPTURE
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        ignore_ecc;
  } job_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  status;
    logic [3:0]  byte_cnt;
    logic [3:0]  pkt_type;
  } res_t;

  localparam int ST_ECC_CORR   = 0;
  localparam int ST_ECC_UNCORR = 1;
  localparam int ST_CRC_ERR    = 2;
  localparam int ST_TIMEOUT    = 3;

endpackage

// File: rtl/pp_sync_fifo.sv
// Single-clock show-ahead FIFO with a registered occupancy count.
// The head word reads as zero while empty so stale entries never leak out.
module pp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/pp_job_sequencer.sv
// Host-side launcher for the packet parser: queues jobs, starts the parser one
// job at a time, waits for its irq (or a timeout) and queues the captured status.
module pp_job_sequencer
  import pp_job_pkg::*;
#(
  parameter int JOB_DEPTH      = 4,
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_addr_hdr,
  input  logic             job_ignore_ecc,
  output logic             pp_start_top,
  output logic [31:0]      pp_addr_hdr_top,
  output logic             pp_ignore_ecc_err_top,
  input  logic             pp_busy_top,
  input  logic             pp_irq_top,
  input  logic             pp_pkt_ecc_corr_top,
  input  logic             pp_pkt_ecc_uncorr_top,
  input  logic             pp_pkt_crc_err_top,
  input  logic [3:0]       pp_pkt_byte_cnt_top,
  input  logic [3:0]       pp_pkt_type_top,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_addr_hdr,
  output logic [3:0]       res_status,
  output logic [3:0]       res_byte_cnt,
  output logic [3:0]       res_pkt_type,
  output logic             irq_out,
  output logic [CNT_W-1:0] err_cnt,
  output logic             spurious_irq
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef logic [TMR_W-1:0] tmr_t;
  typedef logic [CNT_W-1:0] ecnt_t;

  localparam tmr_t  TMR_ONE  = tmr_t'(1);
  localparam tmr_t  TMR_LAST = tmr_t'(TIMEOUT_CYCLES - 1);
  localparam ecnt_t ECNT_ONE = ecnt_t'(1);

  function automatic ecnt_t sat_inc(input ecnt_t v);
    return (&v) ? v : v + ECNT_ONE;
  endfunction

  job_t       job_in, job_head;
  res_t       res_q, res_head;
  logic       job_full, job_empty;
  logic       res_full, res_empty;
  logic       launch_ok, job_pop, res_push;
  state_t     state_q;
  logic       start_q;
  logic [31:0] addr_q;
  logic       ign_q;
  logic       spurious_q;
  tmr_t       timer_q;
  logic       timeout_hit;
  ecnt_t      err_cnt_q, err_cnt_d;
  logic [3:0] irq_status, to_status;
  logic       busy_unused;

  // Busy is informational only; completion is signalled solely by the irq.
  assign busy_unused = pp_busy_top;

  assign job_in.addr       = job_addr_hdr;
  assign job_in.ignore_ecc = job_ignore_ecc;

  pp_sync_fifo #(
    .WIDTH ($bits(job_t)),
    .DEPTH (JOB_DEPTH)
  ) u_job_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (job_valid),
    .push_data (job_in),
    .full      (job_full),
    .pop       (job_pop),
    .pop_data  (job_head),
    .empty     (job_empty)
  );

  pp_sync_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (res_push),
    .push_data (res_q),
    .full      (res_full),
    .pop       (res_ready),
    .pop_data  (res_head),
    .empty     (res_empty)
  );

  // Only launch when the result is guaranteed a slot; nothing is in flight in IDLE.
  assign launch_ok   = !job_empty && !res_full;
  assign job_pop     = (state_q == IDLE) && launch_ok;
  assign res_push    = (state_q == CAPTURE);
  assign timeout_hit = (timer_q == TMR_LAST);

  always_comb begin
    irq_status                = '0;
    irq_status[ST_ECC_CORR]   = pp_pkt_ecc_corr_top;
    irq_status[ST_ECC_UNCORR] = pp_pkt_ecc_uncorr_top;
    irq_status[ST_CRC_ERR]    = pp_pkt_crc_err_top;
    to_status                 = '0;
    to_status[ST_TIMEOUT]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      addr_q     <= '0;
      ign_q      <= 1'b0;
      timer_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (pp_irq_top && (state_q != WAIT_IRQ)) spurious_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (launch_ok) begin
            addr_q  <= job_head.addr;
            ign_q   <= job_head.ignore_ecc;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT_IRQ;
        end
        WAIT_IRQ: begin
          timer_q <= timer_q + TMR_ONE;
          // A simultaneous irq takes priority over the timeout.
          if (pp_irq_top) begin
            res_q.addr     <= addr_q;
            res_q.status   <= irq_status;
            res_q.byte_cnt <= pp_pkt_byte_cnt_top;
            res_q.pkt_type <= pp_pkt_type_top;
            state_q        <= CAPTURE;
          end else if (timeout_hit) begin
            res_q.addr     <= addr_q;
            res_q.status   <= to_status;
            res_q.byte_cnt <= '0;
            res_q.pkt_type <= '0;
            state_q        <= CAPTURE;
          end
        end
        CAPTURE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (res_push && (|res_q.status)) err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign job_ready             = !job_full;
  assign pp_start_top          = start_q;
  assign pp_addr_hdr_top       = addr_q;
  assign pp_ignore_ecc_err_top = ign_q;
  assign res_valid             = !res_empty;
  assign res_addr_hdr          = res_head.addr;
  assign res_status            = res_head.status;
  assign res_byte_cnt          = res_head.byte_cnt;
  assign res_pkt_type          = res_head.pkt_type;
  assign irq_out               = !res_empty;
  assign err_cnt               = err_cnt_q;
  assign spurious_irq          = spurious_q;

endmodule

// File: tb/tb_pp_job_sequencer.sv
// Directed bench for pp_job_sequencer with hand-computed expectations; a short
// timeout and a 2-bit error counter keep timeout and saturation cases cheap.
module tb_pp_job_sequencer;

  localparam int TO = 16;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [31:0]   job_addr_hdr;
  logic          job_ignore_ecc;
  logic          pp_start_top;
  logic [31:0]   pp_addr_hdr_top;
  logic          pp_ignore_ecc_err_top;
  logic          pp_busy_top;
  logic          irq_man, irq_auto;
  logic          pp_pkt_ecc_corr_top;
  logic          pp_pkt_ecc_uncorr_top;
  logic          pp_pkt_crc_err_top;
  logic [3:0]    pp_pkt_byte_cnt_top;
  logic [3:0]    pp_pkt_type_top;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_addr_hdr;
  logic [3:0]    res_status;
  logic [3:0]    res_byte_cnt;
  logic [3:0]    res_pkt_type;
  logic          irq_out;
  logic [CW-1:0] err_cnt;
  logic          spurious_irq;

  pp_job_sequencer #(
    .JOB_DEPTH      (4),
    .RES_DEPTH      (4),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .job_valid             (job_valid),
    .job_ready             (job_ready),
    .job_addr_hdr          (job_addr_hdr),
    .job_ignore_ecc        (job_ignore_ecc),
    .pp_start_top          (pp_start_top),
    .pp_addr_hdr_top       (pp_addr_hdr_top),
    .pp_ignore_ecc_err_top (pp_ignore_ecc_err_top),
    .pp_busy_top           (pp_busy_top),
    .pp_irq_top            (irq_man | irq_auto),
    .pp_pkt_ecc_corr_top   (pp_pkt_ecc_corr_top),
    .pp_pkt_ecc_uncorr_top (pp_pkt_ecc_uncorr_top),
    .pp_pkt_crc_err_top    (pp_pkt_crc_err_top),
    .pp_pkt_byte_cnt_top   (pp_pkt_byte_cnt_top),
    .pp_pkt_type_top       (pp_pkt_type_top),
    .res_valid             (res_valid),
    .res_ready             (res_ready),
    .res_addr_hdr          (res_addr_hdr),
    .res_status            (res_status),
    .res_byte_cnt          (res_byte_cnt),
    .res_pkt_type          (res_pkt_type),
    .irq_out               (irq_out),
    .err_cnt               (err_cnt),
    .spurious_irq          (spurious_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_starts = 0;
  int auto_cnt = 0;
  logic auto_en = 1'b0;

  always @(negedge clk) if (pp_start_top === 1'b1) n_starts++;

  // Parser stand-in: raises irq three cycles after each start pulse.
  always @(posedge clk) begin
    #1;
    irq_auto = 1'b0;
    if (auto_cnt > 0) begin
      auto_cnt--;
      if (auto_cnt == 0) irq_auto = 1'b1;
    end else if (auto_en && pp_start_top) begin
      auto_cnt = 3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [31:0] addr, input logic ign);
    job_valid      = 1'b1;
    job_addr_hdr   = addr;
    job_ignore_ecc = ign;
    step();
    job_valid      = 1'b0;
    job_addr_hdr   = '0;
    job_ignore_ecc = 1'b0;
  endtask

  task automatic pop_res();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // Leaves the bench in the start-pulse cycle when one is seen.
  task automatic wait_start(input string tag, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      if (pp_start_top) seen = 1'b1;
      else step();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // From the start cycle S, drives irq in cycle S+d; returns in cycle S+d+1.
  task automatic irq_pulse(input int d, input logic corr, input logic uncorr,
                           input logic crc, input logic [3:0] bc, input logic [3:0] ty);
    repeat (d) step();
    irq_man               = 1'b1;
    pp_pkt_ecc_corr_top   = corr;
    pp_pkt_ecc_uncorr_top = uncorr;
    pp_pkt_crc_err_top    = crc;
    pp_pkt_byte_cnt_top   = bc;
    pp_pkt_type_top       = ty;
    step();
    irq_man               = 1'b0;
    pp_pkt_ecc_corr_top   = 1'b0;
    pp_pkt_ecc_uncorr_top = 1'b0;
    pp_pkt_crc_err_top    = 1'b0;
    pp_pkt_byte_cnt_top   = '0;
    pp_pkt_type_top       = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int lat;
    logic [31:0] t2_addr [5];

    reset = 1'b1;
    job_valid = 1'b0;
    job_addr_hdr = '0;
    job_ignore_ecc = 1'b0;
    pp_busy_top = 1'b0;
    irq_man = 1'b0;
    irq_auto = 1'b0;
    pp_pkt_ecc_corr_top = 1'b0;
    pp_pkt_ecc_uncorr_top = 1'b0;
    pp_pkt_crc_err_top = 1'b0;
    pp_pkt_byte_cnt_top = '0;
    pp_pkt_type_top = '0;
    res_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_start", 32'(pp_start_top), 32'd0);
    chk("rst_addr", pp_addr_hdr_top, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_irq_out", 32'(irq_out), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_spurious", 32'(spurious_irq), 32'd0);

    // T1: accepted in N, start in N+2, irq at S+5, result visible at S+7.
    base = n_starts;
    push_job(32'h0000_0100, 1'b0);
    chk("t1_no_start_n1", 32'(pp_start_top), 32'd0);
    step();
    chk("t1_start_n2", 32'(pp_start_top), 32'd1);
    chk("t1_pp_addr", pp_addr_hdr_top, 32'h0000_0100);
    chk("t1_pp_ign", 32'(pp_ignore_ecc_err_top), 32'd0);
    irq_pulse(5, 1'b0, 1'b0, 1'b1, 4'd7, 4'd2);
    chk("t1_res_valid_m1", 32'(res_valid), 32'd0);
    chk("t1_addr_stable", pp_addr_hdr_top, 32'h0000_0100);
    step();
    chk("t1_res_valid_m2", 32'(res_valid), 32'd1);
    chk("t1_res_addr", res_addr_hdr, 32'h0000_0100);
    chk("t1_res_status", 32'(res_status), 32'h4);
    chk("t1_byte_cnt", 32'(res_byte_cnt), 32'd7);
    chk("t1_pkt_type", 32'(res_pkt_type), 32'd2);
    chk("t1_err_cnt", 32'(err_cnt), 32'd1);
    repeat (3) step();
    chk("t1_irq_out_held", 32'(irq_out), 32'd1);
    chk("t1_one_start", 32'(n_starts - base), 32'd1);
    pop_res();
    chk("t1_irq_out_pop", 32'(irq_out), 32'd0);
    chk("t1_res_valid_pop", 32'(res_valid), 32'd0);

    // T2: results are never popped, so only RES_DEPTH jobs may launch.
    auto_en = 1'b1;
    base = n_starts;
    for (int i = 0; i < 5; i++) begin
      t2_addr[i] = 32'h0000_1000 + 32'(i * 16);
      push_job(t2_addr[i], 1'b0);
    end
    repeat (60) step();
    chk("t2_four_starts", 32'(n_starts - base), 32'd4);
    chk("t2_res_valid", 32'(res_valid), 32'd1);
    chk("t2_last_launched", pp_addr_hdr_top, t2_addr[3]);
    chk("t2_err_unchanged", 32'(err_cnt), 32'd1);
    chk("t2_head0", res_addr_hdr, t2_addr[0]);
    pop_res();
    repeat (20) step();
    chk("t2_fifth_start", 32'(n_starts - base), 32'd5);
    chk("t2_fifth_addr", pp_addr_hdr_top, t2_addr[4]);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("t2_head%0d", i), res_addr_hdr, t2_addr[i]);
      pop_res();
    end
    chk("t2_drained", 32'(res_valid), 32'd0);
    auto_en = 1'b0;
    repeat (4) step();

    // T3: no irq; the timeout is decided TO cycles after the start pulse,
    // pushed the next cycle and visible on res_valid one cycle later.
    push_job(32'h0000_0300, 1'b1);
    wait_start("t3_start_seen", 10);
    chk("t3_pp_ign", 32'(pp_ignore_ecc_err_top), 32'd1);
    lat = 0;
    while (!res_valid && lat < TO + 10) begin
      step();
      lat++;
    end
    chk("t3_latency", 32'(lat), 32'(TO + 2));
    chk("t3_res_status", 32'(res_status), 32'h8);
    chk("t3_byte_cnt", 32'(res_byte_cnt), 32'd0);
    chk("t3_pkt_type", 32'(res_pkt_type), 32'd0);
    chk("t3_res_addr", res_addr_hdr, 32'h0000_0300);
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);
    pop_res();

    // T4: irq lands on the timeout cycle (timer == TO-1); irq wins.
    push_job(32'h0000_0400, 1'b0);
    wait_start("t4_start_seen", 10);
    irq_pulse(TO, 1'b1, 1'b0, 1'b0, 4'd3, 4'd5);
    step();
    chk("t4_res_valid", 32'(res_valid), 32'd1);
    chk("t4_res_status", 32'(res_status), 32'h1);
    chk("t4_byte_cnt", 32'(res_byte_cnt), 32'd3);
    chk("t4_pkt_type", 32'(res_pkt_type), 32'd5);
    chk("t4_err_cnt", 32'(err_cnt), 32'd3);
    pop_res();

    // Error counter is already all-ones; another error result must not wrap it.
    push_job(32'h0000_0500, 1'b0);
    wait_start("t4b_start_seen", 10);
    irq_pulse(2, 1'b0, 1'b1, 1'b0, 4'd9, 4'd15);
    step();
    chk("t4b_res_status", 32'(res_status), 32'h2);
    chk("t4b_pkt_type", 32'(res_pkt_type), 32'd15);
    chk("t4b_err_sat", 32'(err_cnt), 32'd3);
    pop_res();

    // T5: irq while IDLE sets the sticky flag and pushes nothing.
    repeat (3) step();
    chk("t5_spurious_before", 32'(spurious_irq), 32'd0);
    irq_man = 1'b1;
    step();
    irq_man = 1'b0;
    step();
    chk("t5_spurious_set", 32'(spurious_irq), 32'd1);
    repeat (3) step();
    chk("t5_no_result", 32'(res_valid), 32'd0);
    chk("t5_spurious_sticky", 32'(spurious_irq), 32'd1);
    chk("t5_err_cnt", 32'(err_cnt), 32'd3);

    // T6: reset while waiting for irq with two more jobs queued.
    push_job(32'h0000_0600, 1'b1);
    wait_start("t6_start_seen", 10);
    repeat (3) step();
    push_job(32'h0000_0610, 1'b0);
    push_job(32'h0000_0620, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    base = n_starts;
    chk("t6_job_ready", 32'(job_ready), 32'd1);
    chk("t6_start", 32'(pp_start_top), 32'd0);
    chk("t6_pp_addr", pp_addr_hdr_top, 32'd0);
    chk("t6_pp_ign", 32'(pp_ignore_ecc_err_top), 32'd0);
    chk("t6_res_valid", 32'(res_valid), 32'd0);
    chk("t6_res_addr", res_addr_hdr, 32'd0);
    chk("t6_irq_out", 32'(irq_out), 32'd0);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    chk("t6_spurious", 32'(spurious_irq), 32'd0);
    repeat (30) step();
    chk("t6_no_start_after", 32'(n_starts - base), 32'd0);
    chk("t6_still_empty", 32'(res_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
